// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS bus CPU.
//   - default fetch address after reset
//   - FSM state encoding
//   - primary opcode and R-type funct codes
//   - immediate extension helpers
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_FETCH  = 2'd0;
    localparam state_t ST_EXEC   = 2'd1;
    localparam state_t ST_MEM    = 2'd2;
    localparam state_t ST_HALTED = 2'd3;

    // primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_cpu_regfile.sv
// mips_cpu_regfile: 32 x 32-bit register file, $0 hardwired to zero.
//   clk, reset          : clock, synchronous active-high clear of all registers
//   rs_addr / rs_data   : read port A (combinational)
//   rt_addr / rt_data   : read port B (combinational)
//   we, wr_addr, wr_data: single write port, written on the rising edge
//   v0                  : combinational tap of register $2
module mips_cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] v0
);

    logic [31:0] regs_r [32];

    // register storage; entry 0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (we && (wr_addr != 5'd0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rs_data = regs_r[rs_addr];
    assign rt_data = regs_r[rt_addr];
    assign v0      = regs_r[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multicycle MIPS-I subset CPU on an Avalon-style memory bus.
//   clk, reset   : single clock, synchronous active-high reset
//   active       : high while executing, low once halted (fetch of PC 0)
//   register_v0  : combinational copy of $2
//   address, read, write, byteenable, writedata : bus request
//   waitrequest, readdata                       : bus response
// States: FETCH -> EXEC -> (MEM ->) FETCH; HALTED until reset.
module mips_cpu_bus
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state_r;
    logic [31:0] pc_r, pc_next_r, instr_r;
    logic        active_r;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [31:0] simm_s, zimm_s, rs_data_s, rt_data_s, mem_addr_s;
    logic        is_lw_s, is_sw_s;
    logic        wb_en_s;
    logic [4:0]  wb_addr_s;
    logic [31:0] wb_data_s, target_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;
    logic        read_s, write_s;
    logic [31:0] address_s, writedata_s;
    logic [3:0]  byteenable_s;

    assign opcode_s = instr_r[31:26];
    assign rs_s     = instr_r[25:21];
    assign rt_s     = instr_r[20:16];
    assign rd_s     = instr_r[15:11];
    assign shamt_s  = instr_r[10:6];
    assign funct_s  = instr_r[5:0];
    assign simm_s   = sign_ext16(instr_r[15:0]);
    assign zimm_s   = zero_ext16(instr_r[15:0]);
    assign is_lw_s  = (opcode_s == OP_LW);
    assign is_sw_s  = (opcode_s == OP_SW);
    // misaligned effective addresses are silently word-aligned
    assign mem_addr_s = (rs_data_s + simm_s) & 32'hFFFF_FFFC;

    mips_cpu_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs_s),
        .rt_addr (rt_s),
        .rs_data (rs_data_s),
        .rt_data (rt_data_s),
        .we      (rf_we_s),
        .wr_addr (rf_waddr_s),
        .wr_data (rf_wdata_s),
        .v0      (register_v0)
    );

    // decode/execute: ALU result, writeback target and the next PC_next
    always_comb begin
        wb_en_s   = 1'b0;
        wb_addr_s = rt_s;
        wb_data_s = 32'h0000_0000;
        target_s  = pc_next_r + 32'd4;
        case (opcode_s)
            OP_RTYPE: begin
                wb_addr_s = rd_s;
                wb_en_s   = 1'b1;
                case (funct_s)
                    FN_ADDU: wb_data_s = rs_data_s + rt_data_s;
                    FN_SUBU: wb_data_s = rs_data_s - rt_data_s;
                    FN_AND:  wb_data_s = rs_data_s & rt_data_s;
                    FN_OR:   wb_data_s = rs_data_s | rt_data_s;
                    FN_XOR:  wb_data_s = rs_data_s ^ rt_data_s;
                    FN_SLT:  wb_data_s = {31'd0, $signed(rs_data_s) < $signed(rt_data_s)};
                    FN_SLTU: wb_data_s = {31'd0, rs_data_s < rt_data_s};
                    FN_SLL:  wb_data_s = rt_data_s << shamt_s;
                    FN_SRL:  wb_data_s = rt_data_s >> shamt_s;
                    FN_SRA:  wb_data_s = $signed(rt_data_s) >>> shamt_s;
                    FN_JR: begin
                        wb_en_s  = 1'b0;
                        target_s = rs_data_s;
                    end
                    FN_JALR: begin
                        wb_data_s = pc_r + 32'd8;
                        target_s  = rs_data_s;
                    end
                    default: wb_en_s = 1'b0;
                endcase
            end
            OP_ADDIU: begin wb_en_s = 1'b1; wb_data_s = rs_data_s + simm_s; end
            OP_ANDI:  begin wb_en_s = 1'b1; wb_data_s = rs_data_s & zimm_s; end
            OP_ORI:   begin wb_en_s = 1'b1; wb_data_s = rs_data_s | zimm_s; end
            OP_XORI:  begin wb_en_s = 1'b1; wb_data_s = rs_data_s ^ zimm_s; end
            OP_SLTI:  begin wb_en_s = 1'b1; wb_data_s = {31'd0, $signed(rs_data_s) < $signed(simm_s)}; end
            OP_SLTIU: begin wb_en_s = 1'b1; wb_data_s = {31'd0, rs_data_s < simm_s}; end
            OP_LUI:   begin wb_en_s = 1'b1; wb_data_s = {instr_r[15:0], 16'h0000}; end
            OP_BEQ: begin
                if (rs_data_s == rt_data_s) begin
                    target_s = pc_next_r + (simm_s << 2);
                end else begin
                    target_s = pc_next_r + 32'd4;
                end
            end
            OP_BNE: begin
                if (rs_data_s != rt_data_s) begin
                    target_s = pc_next_r + (simm_s << 2);
                end else begin
                    target_s = pc_next_r + 32'd4;
                end
            end
            OP_J: target_s = {pc_next_r[31:28], instr_r[25:0], 2'b00};
            OP_JAL: begin
                target_s  = {pc_next_r[31:28], instr_r[25:0], 2'b00};
                wb_en_s   = 1'b1;
                wb_addr_s = 5'd31;
                wb_data_s = pc_r + 32'd8;
            end
            default: wb_en_s = 1'b0;
        endcase
    end

    // register write port: ALU writeback in EXEC, load data when MEM completes
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = wb_addr_s;
        rf_wdata_s = wb_data_s;
        if (reset) begin
            rf_we_s = 1'b0;
        end else if (state_r == ST_EXEC) begin
            rf_we_s = wb_en_s;
        end else if ((state_r == ST_MEM) && is_lw_s && !waitrequest) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = rt_s;
            rf_wdata_s = readdata;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // bus request derived from the registered state
    always_comb begin
        read_s       = 1'b0;
        write_s      = 1'b0;
        address_s    = 32'h0000_0000;
        writedata_s  = 32'h0000_0000;
        byteenable_s = 4'b0000;
        case (state_r)
            ST_FETCH: begin
                if (pc_r != 32'h0000_0000) begin
                    read_s       = 1'b1;
                    address_s    = pc_r;
                    byteenable_s = 4'b1111;
                end else begin
                    read_s = 1'b0;
                end
            end
            ST_MEM: begin
                address_s    = mem_addr_s;
                byteenable_s = 4'b1111;
                if (is_sw_s) begin
                    write_s     = 1'b1;
                    writedata_s = rt_data_s;
                end else begin
                    read_s = 1'b1;
                end
            end
            default: read_s = 1'b0;
        endcase
    end

    assign read       = read_s  & ~reset;
    assign write      = write_s & ~reset;
    assign address    = address_s;
    assign writedata  = writedata_s;
    assign byteenable = byteenable_s;
    assign active     = active_r;

    // control FSM and PC / delay-slot pair
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_VECTOR;
            pc_next_r <= RESET_VECTOR + 32'd4;
            instr_r   <= 32'h0000_0000;
            active_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (pc_r == 32'h0000_0000) begin
                        state_r  <= ST_HALTED;
                        active_r <= 1'b0;
                    end else if (!waitrequest) begin
                        instr_r <= readdata;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc_r      <= pc_next_r;
                    pc_next_r <= target_s;
                    state_r   <= (is_lw_s || is_sw_s) ? ST_MEM : ST_FETCH;
                end
                ST_MEM: begin
                    if (!waitrequest) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    state_r  <= ST_HALTED;
                    active_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_HALTED;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Scoreboard bench for mips_cpu_bus: an instruction-level reference model
// predicts every bus transaction and the final $2; a negedge monitor drives
// the memory/stall response and pops expectations as transactions complete.
module tb_mips_cpu_bus;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active, read, write;
    logic        waitrequest = 1'b0;
    logic [31:0] register_v0, address, writedata;
    logic [31:0] readdata = 32'h0;
    logic [3:0]  byteenable;

    mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] prog[$];
    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] ref_regs [32];
    int n_checks = 0;
    int n_pass   = 0;
    int stall_mode = 0;
    int stall_cnt = 0;
    int stall_target = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic int new_stall();
        if (stall_mode == 0) return 0;
        if (stall_mode == 1) return 15;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return 32'h0;
    endfunction

    // memory slave + scoreboard monitor, all decided on the falling edge
    initial begin
        logic        prev_stall = 1'b0;
        logic [1:0]  prev_rw = 2'b00;
        logic [31:0] prev_addr = 32'h0;
        txn_t        e;
        forever begin
            @(negedge clk);
            if (!reset && (read || write)) begin
                if (stall_cnt < stall_target) begin
                    waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    waitrequest = 1'b0;
                    stall_cnt = 0;
                    stall_target = new_stall();
                end
            end else begin
                waitrequest = 1'b0;
                stall_cnt = 0;
            end
            readdata = mem_rd(address);
            if (!reset) begin
                check("rw_exclusive", {31'd0, read & write}, 32'd0);
                if (prev_stall) begin
                    check("stall_hold_addr", address, prev_addr);
                    check("stall_hold_strobe", {30'd0, read, write}, {30'd0, prev_rw});
                end
            end
            if (!reset && (read || write) && !waitrequest) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_txn: got wr=%0b addr %08h expected none", write, address);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_kind", {31'd0, write}, {31'd0, e.wr});
                    check("txn_addr", address, e.addr);
                    check("txn_be", {28'd0, byteenable}, 32'h0000_000F);
                    if (e.wr) check("txn_wdata", writedata, e.data);
                end
                if (write) mem[address[31:2]] = writedata;
            end
            prev_stall = !reset && (read || write) && waitrequest;
            prev_rw    = {read, write};
            prev_addr  = address;
        end
    end

    function automatic void setr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) ref_regs[idx] = v;
    endfunction

    // instruction-level reference model: sequential ISA semantics with one delay slot
    task automatic ref_run(output logic [31:0] v0);
        logic [31:0] pc, npc, ins, a, b, tgt, ea, simm, zimm;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        pc = RV;
        npc = RV + 32'd4;
        for (int step = 0; step < 4000 && pc != 32'h0; step++) begin
            exp_q.push_back(txn_t'{wr: 1'b0, addr: pc, data: 32'h0});
            ins = ref_mem.exists(pc[31:2]) ? ref_mem[pc[31:2]] : 32'h0;
            {op, rs, rt, rd, sh, fn} = ins;
            simm = {{16{ins[15]}}, ins[15:0]};
            zimm = {16'h0, ins[15:0]};
            a = ref_regs[rs];
            b = ref_regs[rt];
            tgt = npc + 32'd4;
            ea = (a + simm) & 32'hFFFF_FFFC;
            case (op)
                6'h00: case (fn)
                    6'h21: setr(rd, a + b);
                    6'h23: setr(rd, a - b);
                    6'h24: setr(rd, a & b);
                    6'h25: setr(rd, a | b);
                    6'h26: setr(rd, a ^ b);
                    6'h2A: setr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h2B: setr(rd, (a < b) ? 32'd1 : 32'd0);
                    6'h00: setr(rd, b << sh);
                    6'h02: setr(rd, b >> sh);
                    6'h03: setr(rd, $signed(b) >>> sh);
                    6'h08: tgt = a;
                    6'h09: begin tgt = a; setr(rd, pc + 32'd8); end
                    default: ;
                endcase
                6'h09: setr(rt, a + simm);
                6'h0C: setr(rt, a & zimm);
                6'h0D: setr(rt, a | zimm);
                6'h0E: setr(rt, a ^ zimm);
                6'h0A: setr(rt, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0);
                6'h0B: setr(rt, (a < simm) ? 32'd1 : 32'd0);
                6'h0F: setr(rt, {ins[15:0], 16'h0});
                6'h23: begin
                    exp_q.push_back(txn_t'{wr: 1'b0, addr: ea, data: 32'h0});
                    setr(rt, ref_mem.exists(ea[31:2]) ? ref_mem[ea[31:2]] : 32'h0);
                end
                6'h2B: begin
                    exp_q.push_back(txn_t'{wr: 1'b1, addr: ea, data: b});
                    ref_mem[ea[31:2]] = b;
                end
                6'h04: if (a == b) tgt = npc + (simm << 2);
                6'h05: if (a != b) tgt = npc + (simm << 2);
                6'h02: tgt = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin tgt = {npc[31:28], ins[25:0], 2'b00}; setr(5'd31, pc + 32'd8); end
                default: ;
            endcase
            pc = npc;
            npc = tgt;
        end
        v0 = ref_regs[2];
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] dst);
        return {op, dst[27:2]};
    endfunction

    function automatic logic [31:0] rand_alu();
        logic [5:0] rfn, iop;
        logic [4:0] s, t, d;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(1, 7));
        case ($urandom_range(0, 9))
            0: rfn = 6'h21; 1: rfn = 6'h23; 2: rfn = 6'h24; 3: rfn = 6'h25; 4: rfn = 6'h26;
            5: rfn = 6'h2A; 6: rfn = 6'h2B; 7: rfn = 6'h00; 8: rfn = 6'h02; default: rfn = 6'h03;
        endcase
        case ($urandom_range(0, 6))
            0: iop = 6'h09; 1: iop = 6'h0C; 2: iop = 6'h0D; 3: iop = 6'h0E;
            4: iop = 6'h0A; 5: iop = 6'h0B; default: iop = 6'h0F;
        endcase
        if ($urandom_range(0, 1) == 0) return enc_r(rfn, s, t, d, 5'($urandom));
        return enc_i(iop, s, d, 16'($urandom));
    endfunction

    task automatic gen_rand_prog();
        logic [15:0] off;
        prog.delete();
        for (int i = 0; i < 30; i++) begin
            off = 16'h0100 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                7: prog.push_back(enc_i(($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B, 5'd0,
                                        5'($urandom_range(1, 7)), off));
                8: prog.push_back(($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)}
                                                              : enc_r(6'h18, 5'd3, 5'd4, 5'd0, 5'd0));
                9: begin
                    prog.push_back(enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05,
                                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         16'($urandom_range(1, 3))));
                    prog.push_back(rand_alu());
                end
                default: prog.push_back(rand_alu());
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            prog.push_back(enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0));
            prog.push_back(32'h0);
        end
    endtask

    task automatic run_prog(input string name, input int smode, input bit has_c, input logic [31:0] cv);
        logic [31:0] ev, a, w;
        int cyc;
        mem.delete();
        ref_mem.delete();
        exp_q.delete();
        foreach (prog[i]) begin
            a = RV + 32'(i * 4);
            mem[a[31:2]] = prog[i];
            ref_mem[a[31:2]] = prog[i];
        end
        for (int i = 0; i < 16; i++) begin
            a = 32'h0000_0100 + 32'(i * 4);
            w = $urandom;
            mem[a[31:2]] = w;
            ref_mem[a[31:2]] = w;
        end
        stall_mode = smode;
        ref_run(ev);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("reset_read", {31'd0, read}, 32'd0);
            check("reset_write", {31'd0, write}, 32'd0);
        end
        stall_target = new_stall();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("active_after_reset", {31'd0, active}, 32'd1);
        check("first_fetch_addr", address, RV);
        cyc = 0;
        while (active !== 1'b0 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 30000) begin
            n_checks++;
            $display("FAIL %s_timeout: got active=%0b expected 0 within 30000 cycles", name, active);
        end
        repeat (3) @(negedge clk);
        check("halt_no_read", {31'd0, read}, 32'd0);
        check("halt_no_write", {31'd0, write}, 32'd0);
        check("all_txns_seen", 32'(exp_q.size()), 32'd0);
        check({name, "_v0_model"}, register_v0, ev);
        if (has_c) check({name, "_v0_const"}, register_v0, cv);
    endtask

    initial begin
        // LUI/ORI into $2 then halt through JR $0
        prog = '{enc_i(6'h0F, 5'd0, 5'd2, 16'h1234), enc_i(6'h0D, 5'd2, 5'd2, 16'h5678),
                 enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0), 32'h0};
        run_prog("lui_ori", 0, 1'b1, 32'h1234_5678);

        // store then load back through memory
        prog = '{enc_i(6'h09, 5'd0, 5'd3, 16'd5), enc_i(6'h2B, 5'd0, 5'd3, 16'h0100),
                 enc_i(6'h23, 5'd0, 5'd2, 16'h0100), enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0), 32'h0};
        run_prog("sw_lw", 0, 1'b1, 32'h0000_0005);
        run_prog("sw_lw_stall15", 1, 1'b1, 32'h0000_0005);

        // taken branch: delay slot executes, next instruction skipped
        prog = '{enc_i(6'h04, 5'd0, 5'd0, 16'd2), enc_i(6'h09, 5'd2, 5'd2, 16'd1),
                 enc_i(6'h09, 5'd2, 5'd2, 16'd16), enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0), 32'h0};
        run_prog("beq_delay", 0, 1'b1, 32'h0000_0001);
        run_prog("beq_delay_stall15", 1, 1'b1, 32'h0000_0001);

        // writes to $0 are discarded
        prog = '{enc_i(6'h09, 5'd0, 5'd0, 16'd7), enc_r(6'h21, 5'd0, 5'd0, 5'd2, 5'd0),
                 enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0), 32'h0};
        run_prog("zero_reg", 0, 1'b1, 32'h0000_0000);

        // JAL / JALR link values and jump targets
        prog = '{enc_j(6'h03, RV + 32'h20), enc_i(6'h09, 5'd0, 5'd2, 16'd3),
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 enc_r(6'h23, 5'd31, 5'd2, 5'd2, 5'd0), enc_i(6'h0F, 5'd0, 5'd4, 16'hBFC0),
                 enc_i(6'h0D, 5'd4, 5'd4, 16'h0040), enc_r(6'h09, 5'd4, 5'd0, 5'd6, 5'd0),
                 enc_i(6'h09, 5'd2, 5'd2, 16'd1), enc_i(6'h09, 5'd2, 5'd2, 16'd64),
                 32'h0, 32'h0,
                 enc_r(6'h21, 5'd2, 5'd6, 5'd2, 5'd0), enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0), 32'h0};
        run_prog("jal_jalr", 2, 1'b1, 32'h7F80_003A);

        // randomized programs under each stall policy
        for (int t = 0; t < 6; t++) begin
            gen_rand_prog();
            run_prog("random", t % 3, 1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus.md
MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first instruction fetch address.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port active, output, 1 bit: high while executing, low once halted.
REQ-005 SHALL have port register_v0, output, 32 bits: combinational copy of register $2.
REQ-006 SHALL have port address, output, 32 bits: word-aligned bus address.
REQ-007 SHALL have ports read and write, outputs, 1 bit each: bus request strobes.
REQ-008 SHALL have port waitrequest, input, 1 bit: memory stall.
REQ-009 SHALL have port writedata, output, 32 bits: store data.
REQ-010 SHALL have port byteenable, output, 4 bits: lane enables.
REQ-011 SHALL have port readdata, input, 32 bits: load and fetch data.

Function
REQ-012 SHALL be a multicycle FSM with states FETCH, EXEC, MEM and HALTED.
REQ-013 FETCH SHALL assert read=1, address=PC, byteenable=4'b1111, and SHALL hold them until an edge with waitrequest=0, latching readdata as the instruction and moving to EXEC.
REQ-014 read and write SHALL never be high together; both SHALL be 0 in EXEC and HALTED.
REQ-015 EXEC SHALL decode and execute in one cycle, writing the ALU result back, then go to FETCH, or to MEM for LW/SW.
REQ-016 MEM SHALL assert read (LW) or write (SW) with address=rs+sign-extended imm and byteenable=4'b1111; SW SHALL drive writedata=rt.
REQ-017 MEM SHALL complete on the edge with waitrequest=0; LW SHALL then write readdata to rt; both SHALL go to FETCH.
REQ-018 Supported instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-019 Any other encoding SHALL execute as a NOP.
REQ-020 Arithmetic SHALL be 32-bit wrap-around with no overflow exceptions.
REQ-021 ANDI, ORI and XORI SHALL zero-extend imm; all other immediate instructions SHALL sign-extend it.
REQ-022 Branches and jumps SHALL have one delay slot: the FSM SHALL keep PC and PC_next, and each EXEC SHALL set PC<=PC_next and PC_next<=target or PC_next+4.
REQ-023 Branch target SHALL be delay-slot address + (sign-extended imm << 2); J/JAL target SHALL be {PC_delay[31:28], index, 2'b00}.
REQ-024 JAL/JALR SHALL write the branch address+8 to $31 (JALR: to rd).
REQ-025 Writes to $0 SHALL be discarded and reads of $0 SHALL return 0.
REQ-026 Halt: when the PC about to be fetched equals 0x00000000, the FSM SHALL enter HALTED with active=0 and no bus activity, and SHALL stay there until reset.
REQ-027 Misaligned LW/SW addresses SHALL be accessed with the low two address bits forced to 0.

Reset
REQ-028 While reset=1, read and write SHALL be 0 (gated combinationally by reset).
REQ-029 On each edge with reset=1: PC<=RESET_VECTOR, PC_next<=RESET_VECTOR+4, all registers<=0, state<=FETCH, active<=1.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no register or memory write.
REQ-031 active SHALL be 1 at the first rising edge after reset falls.

Structure
REQ-032 A shared package mips_pkg SHALL hold the opcode/funct constants, the state enum and RESET_VECTOR's default.
REQ-033 The 32x32 register file (2 read ports, 1 write port, $2 tap) SHALL be a sub-module named mips_cpu_regfile.

Verification
REQ-034 Hold reset high for 4 cycles -> read=write=0 at every edge; after release, active=1 and the first read address is 0xBFC00000.
REQ-035 Program LUI $2,0x1234; ORI $2,$2,0x5678; JR $0; NOP -> active falls; register_v0=0x12345678.
REQ-036 Program ADDIU $3,$0,5; SW $3,0x100($0); LW $2,0x100($0); then halt -> register_v0=0x00000005; the SW drives byteenable=4'hF and writedata=5.
REQ-037 Program BEQ $0,$0,+2 with ADDIU $2,$2,1 in the delay slot and a skipped ADDIU $2,$2,16 -> register_v0=1.
REQ-038 Memory stalls 15 cycles per access -> results identical to the zero-stall run, with read held stable throughout each stall.
REQ-039 Program ADDIU $0,$0,7; ADDU $2,$0,$0 -> register_v0=0.
